// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - MDU opcode enum and decode helpers shared by decoder, hazard unit and MDU
// Purpose: defines the MDU operation encoding and small classification helpers.
// Ports: none (package).
package mdu_pkg;

  // Nine operations need four bits of encoding.
  localparam int MDU_OP_W = 4;

  typedef enum logic [MDU_OP_W-1:0] {
    NONE  = 4'd0,
    MULT  = 4'd1,
    MULTU = 4'd2,
    DIV   = 4'd3,
    DIVU  = 4'd4,
    MTHI  = 4'd5,
    MTLO  = 4'd6,
    MFHI  = 4'd7,
    MFLO  = 4'd8
  } mdu_op_e;

  // True for every instruction that touches the MDU; the hazard unit uses this
  // to hold such an instruction in D while the unit is busy.
  function automatic logic is_mdu_op(mdu_op_e op);
    case (op)
      MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

  // Operations that occupy the unit for several cycles.
  function automatic logic is_multi_cycle(mdu_op_e op);
    case (op)
      MULT, MULTU, DIV, DIVU: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic is_div(mdu_op_e op);
    return (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational 64-bit multiply/divide result from latched operands
// Purpose: produces {hi,lo} for MULT/MULTU ({hi,lo}=product) and DIV/DIVU
//          ({hi,lo}={remainder,quotient}); flags a zero divisor.
// Ports:
//   op          in  4   latched operation (mdu_op_e encoding)
//   a           in  32  latched operand A (multiplicand / dividend)
//   b           in  32  latched operand B (multiplier / divisor)
//   result      out 64  {hi,lo} candidate
//   div_by_zero out 1   b == 0
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_by_zero
);

  mdu_op_e op_e;
  assign op_e = mdu_op_e'(op);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] b_safe;
  logic [31:0] uq, ur;
  logic [31:0] a_mag, b_mag;
  logic [31:0] mq, mr;
  logic [31:0] sq, sr;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // A zero divisor is replaced by 1 so the dividers never see zero; the top
  // discards the result in that case anyway.
  assign div_by_zero = (b == 32'd0);
  assign b_safe      = div_by_zero ? 32'd1 : b;

  assign uq = a / b_safe;
  assign ur = a % b_safe;

  // Signed divide via magnitudes: truncation toward zero falls out naturally,
  // and 0x80000000 / -1 yields magnitude 0x80000000 with a positive sign,
  // i.e. the wrapped quotient 0x80000000 and remainder 0.
  assign a_mag = a[31] ? (~a + 32'd1) : a;
  assign b_mag = b_safe[31] ? (~b_safe + 32'd1) : b_safe;
  assign mq    = a_mag / b_mag;
  assign mr    = a_mag % b_mag;
  assign sq    = (a[31] ^ b_safe[31]) ? (~mq + 32'd1) : mq;
  assign sr    = a[31] ? (~mr + 32'd1) : mr;   // remainder follows the dividend

  always_comb begin
    result = 64'd0;
    case (op_e)
      MULT:    result = prod_s;
      MULTU:   result = prod_u;
      DIV:     result = {sr, sq};
      DIVU:    result = {ur, uq};
      default: result = 64'd0;
    endcase
  end

endmodule

// File: rtl/e_mul_div_unit.sv
// rtl/e_mul_div_unit.sv - execute-stage multiply/divide unit with HI/LO registers
// Purpose: accepts MULT/MULTU/DIV/DIVU (multi-cycle, busy) and MTHI/MTLO
//          (single-cycle); holds architectural HI/LO, readable every cycle.
// Parameters: MULT_CYCLES, DIV_CYCLES - busy cycles per operation class (>=1).
// Ports:
//   clk      in  1   clock
//   reset    in  1   synchronous, active-high
//   start    in  1   valid MDU op in E this cycle
//   mdu_op   in  4   operation (mdu_op_e encoding)
//   rs_data  in  32  operand A / MT source
//   rt_data  in  32  operand B
//   busy     out 1   multi-cycle op in flight
//   hi       out 32  architectural HI
//   lo       out 32  architectural LO
module e_mul_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic [3:0]       op_q;
  logic [31:0]      a_q, b_q;
  logic [31:0]      hi_q, lo_q;

  mdu_op_e          op_in;
  logic             accept;
  logic             complete;
  logic             mt_write;
  logic [63:0]      result;
  logic             div_by_zero;

  assign op_in = mdu_op_e'(mdu_op);

  mdu_arith u_arith (
    .op          (op_q),
    .a           (a_q),
    .b           (b_q),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  // Next-state and control strobes. start is only honoured in IDLE; while BUSY
  // it is ignored outright (including MTHI/MTLO).
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    complete = 1'b0;
    mt_write = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && is_multi_cycle(op_in)) begin
          accept  = 1'b1;
          state_d = S_BUSY;
        end else if (start && (op_in == MTHI || op_in == MTLO)) begin
          mt_write = 1'b1;
        end
      end
      S_BUSY: begin
        if (count_q == '0) begin
          complete = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      op_q    <= NONE;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;

      // Loading N-1 means busy is high for exactly N cycles and the result
      // lands on the N-th edge after the accepting one.
      if (accept) begin
        op_q    <= mdu_op;
        a_q     <= rs_data;
        b_q     <= rt_data;
        count_q <= is_div(op_in) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
      end else if (state_q == S_BUSY && count_q != '0) begin
        count_q <= count_q - CNT_W'(1);
      end

      // HI/LO change together at completion; a zero divisor leaves both intact.
      if (complete && !(is_div(mdu_op_e'(op_q)) && div_by_zero)) begin
        hi_q <= result[63:32];
        lo_q <= result[31:0];
      end

      if (mt_write) begin
        if (op_in == MTHI) hi_q <= rs_data;
        else               lo_q <= rs_data;
      end
    end
  end

  assign busy = (state_q == S_BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_e_mul_div_unit.sv
// tb/tb_e_mul_div_unit.sv - directed self-checking bench for e_mul_div_unit
module tb_e_mul_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int passed = 0;

  e_mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .mdu_op  (mdu_op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start   = 1'b1;
    mdu_op  = op;
    rs_data = a;
    rt_data = b;
    tick();
    start   = 1'b0;
    mdu_op  = NONE;
  endtask

  // Called just after the accepting edge: busy for n cycles, HI/LO frozen until the last edge.
  task automatic run_multi(input string tag, input int n,
                           input logic [31:0] old_hi, input logic [31:0] old_lo,
                           input logic [31:0] new_hi, input logic [31:0] new_lo);
    check({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
    repeat (n - 1) tick();
    check({tag, "_busy_last"}, {31'd0, busy}, 32'd1);
    check({tag, "_hi_hold"}, hi, old_hi);
    check({tag, "_lo_hold"}, lo, old_lo);
    tick();
    check({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
    check({tag, "_hi"}, hi, new_hi);
    check({tag, "_lo"}, lo, new_lo);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    mdu_op  = NONE;
    rs_data = 32'd0;
    rt_data = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    // MULT -2 * 3
    issue(MULT, 32'hFFFF_FFFE, 32'd3);
    rs_data = 32'h5555_5555;   // operands already latched
    rt_data = 32'hAAAA_AAAA;
    run_multi("mult", 5, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    // MULTU 0xFFFFFFFF^2
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_multi("multu", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'h0000_0001);

    // DIV -7 / 2 -> q=-3, r=-1
    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    run_multi("div_neg", 10, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // DIV overflow case
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_multi("div_ovf", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0000, 32'h8000_0000);

    // MTHI single cycle
    issue(MTHI, 32'h1234_5678, 32'd0);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_lo", lo, 32'h8000_0000);

    // DIVU by zero leaves HI/LO untouched
    issue(DIVU, 32'd5, 32'd0);
    run_multi("divu_zero", 10, 32'h1234_5678, 32'h8000_0000, 32'h1234_5678, 32'h8000_0000);

    // Start while busy is ignored; reset mid-op drops the result
    issue(DIV, 32'd100, 32'd7);
    tick();
    tick();
    start   = 1'b1;
    mdu_op  = MTLO;
    rs_data = 32'hDEAD_BEEF;
    tick();
    start   = 1'b0;
    mdu_op  = NONE;
    check("ign_busy", {31'd0, busy}, 32'd1);
    check("ign_lo", lo, 32'h8000_0000);
    check("ign_hi", hi, 32'h1234_5678);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    repeat (12) tick();
    check("late_hi", hi, 32'd0);
    check("late_lo", lo, 32'd0);
    check("late_busy", {31'd0, busy}, 32'd0);

    // Back-to-back: MULTU held on the edge where MULT completes
    issue(MULT, 32'd7, 32'hFFFF_FFFA);
    check("b2b_busy1", {31'd0, busy}, 32'd1);
    repeat (4) tick();
    start   = 1'b1;
    mdu_op  = MULTU;
    rs_data = 32'h0001_0000;
    rt_data = 32'h0001_0000;
    tick();
    check("b2b_fall", {31'd0, busy}, 32'd0);
    check("b2b_hi1", hi, 32'hFFFF_FFFF);
    check("b2b_lo1", lo, 32'hFFFF_FFD6);
    tick();
    start   = 1'b0;
    mdu_op  = NONE;
    rs_data = 32'hFFFF_FFFF;
    rt_data = 32'hFFFF_FFFF;
    run_multi("b2b_multu", 5, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 32'h0000_0001, 32'h0000_0000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
